seq_loader: RTL and testbench
=============================

# seq_loader

Parametrised sequence loader for the Simon Says datapath. Pulls random words from the LFSR through a request/valid handshake and writes them into the pattern memory. It supports two modes: full refill of DEPTH entries, or appending one entry per round. It maintains a persistent fill count and sits between the top-level game FSM and the LFSR/pattern memory.

## Interface
- DATA_W, 8, width of an LFSR word and a memory entry
- DEPTH, 4, pattern memory entries; must be ≥2
- ADDR_W, $clog2(DEPTH), derived; do not override
- clk  in  1  system clock, all state on rising edge
- rst_n_SEQ  in  1  asynchronous, active-low reset
- en_SEQ  in  1  block enable
- start  in  1  one-cycle request to run one operation; sampled only in IDLE
- mode  in  1  0 = FILL, 1 = APPEND; sampled with start
- clear  in  1  zero the fill count; honoured only in IDLE
- lfsr_valid  in  1  LFSR word ready (complete_LFSR equivalent)
- lfsr_data  in  DATA_W  LFSR word
- lfsr_req  out  1  LFSR run/request
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- count  out  ADDR_W+1  valid entries, 0..DEPTH
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- overflow  out  1  one-cycle pulse, coincident with done, when an APPEND is rejected

## Operation
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, count is 0, and the internal "armed" flag is 0.
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - If en_SEQ && clear, count is set to 0.
  - If en_SEQ && start && mode=0: count is set to 0 and the block enters REQ.
  - If en_SEQ && start && mode=1 && count<DEPTH: the block enters REQ.
  - If en_SEQ && start && mode=1 && count==DEPTH: the block enters DONE with overflow set; there is no LFSR request and no write.
  - clear and start in the same cycle: clear is applied first, then start is evaluated against count=0.
- REQ:
  - lfsr_req=1 while en_SEQ=1.
  - lfsr_valid is accepted only when armed=1. armed is set after one REQ cycle with lfsr_req=1 and is cleared when leaving REQ. This rejects a stale valid left over from the previous word.
  - On accept: mem_wdata<=lfsr_data, mem_addr<=count[ADDR_W-1:0], mem_we<=1, lfsr_req<=0, and the block enters WRITE.
  - en_SEQ=0 in REQ: lfsr_req<=0, armed<=0, and the block stays in REQ. Progress resumes when en_SEQ returns.
- WRITE:
  - The write strobe is active this cycle.
  - WRITE always completes regardless of en_SEQ.
  - mem_we<=0 and count<=count+1.
  - FILL mode: if count+1 < DEPTH the next state is REQ, otherwise DONE.
  - APPEND mode: the next state is always DONE.
- DONE: done=1 (and overflow if flagged) for exactly one cycle, then IDLE. busy drops on entry to IDLE.
- start, mode, or clear while busy: ignored. mode is latched at start.
- count never exceeds DEPTH and never wraps.
- mem_addr is count truncated to ADDR_W bits. It is always < DEPTH when mem_we=1.

## Timing
- start sampled at edge t0: busy=1 and lfsr_req=1 from t0+1.
- Earliest accept is at t0+2. The lfsr_valid that was high at t0+1 is ignored because armed=0.
- Accept at edge ta: mem_we=1 during ta+1..ta+2 (one cycle, in WRITE).
- lfsr_req is low for at least one cycle between words.
- FILL with lfsr_valid permanently high: each word takes 3 cycles (REQ unarmed, REQ armed, WRITE). done is high one cycle after the last WRITE. Total from start to done is 3·DEPTH+1 cycles.
- APPEND with lfsr_valid permanently high: done 4 cycles after start.
- APPEND when full: done and overflow 1 cycle after start.
- Reset asserted mid-operation: immediate return to reset values. mem_we drops asynchronously; any partially loaded sequence is discarded (count=0).

## Test plan
- Reset: hold rst_n_SEQ=0 with garbage inputs → all outputs 0. Release, pulse start mode=0 with DEPTH=4 and lfsr_valid=1 and lfsr_data stepping 8'hA1, A2, … → four writes to addr 0,1,2,3 with the data present at each accept; done 13 cycles after start; count=4.
- Stale-valid rejection: lfsr_valid held high from before start → no write in the first REQ cycle; the first mem_we is at start+3.
- APPEND rounds: clear, then 4× start mode=1 → writes to addr 0,1,2,3 one per operation; count goes 1→4. A fifth start → done+overflow at start+1, mem_we never asserted, count stays 4.
- Enable stall: drop en_SEQ for 5 cycles while in REQ → lfsr_req=0 and no write. Restore en_SEQ → re-arm cycle, then the write proceeds at the correct address.
- Busy filtering: pulse start, clear, and mode=1 during a FILL → no effect; the FILL completes with count=4.
- Async reset during WRITE: assert rst_n_SEQ mid-cycle → mem_we falls without waiting for a clock edge; count=0; state IDLE.

Source files
------------

// File: rtl/seq_loader.sv
// Sequence loader: pulls words from the LFSR over a req/valid handshake and
// writes them into the pattern memory, either as a full refill or one append.
module seq_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n_SEQ,
  input  logic              en_SEQ,
  input  logic              start,
  input  logic              mode,
  input  logic              clear,
  input  logic              lfsr_valid,
  input  logic [DATA_W-1:0] lfsr_data,
  output logic              lfsr_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [1:0]      state;
  logic            armed;
  logic            mode_q;
  logic [ADDR_W:0] count_inc;
  logic [ADDR_W:0] count_base;

  assign count_inc  = count + (ADDR_W+1)'(1);
  // A same-cycle clear is applied before start looks at the fill level.
  assign count_base = clear ? '0 : count;

  // NOTE: every register uses non-blocking assignment so all decisions in a
  // cycle see the pre-edge values; the async reset also drops mem_we at once.
  always_ff @(posedge clk or negedge rst_n_SEQ) begin
    if (!rst_n_SEQ) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      mode_q    <= 1'b0;
      lfsr_req  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_SEQ) begin
            if (clear) count <= '0;
            if (start) begin
              mode_q <= mode;
              busy   <= 1'b1;
              if (!mode) begin
                count    <= '0;
                lfsr_req <= 1'b1;
                state    <= S_REQ;
              end else if (count_base < FULL) begin
                lfsr_req <= 1'b1;
                state    <= S_REQ;
              end else begin
                done     <= 1'b1;
                overflow <= 1'b1;
                state    <= S_DONE;
              end
            end
          end
        end

        S_REQ: begin
          if (!en_SEQ) begin
            lfsr_req <= 1'b0;
            armed    <= 1'b0;
          end else if (armed && lfsr_valid) begin
            mem_wdata <= lfsr_data;
            mem_addr  <= count[ADDR_W-1:0];
            mem_we    <= 1'b1;
            lfsr_req  <= 1'b0;
            armed     <= 1'b0;
            state     <= S_WRITE;
          end else if (lfsr_req) begin
            // One full request cycle must pass before a valid is trusted.
            armed <= 1'b1;
          end else begin
            lfsr_req <= 1'b1;
          end
        end

        S_WRITE: begin
          mem_we <= 1'b0;
          count  <= count_inc;
          if (!mode_q && (count_inc < FULL)) begin
            lfsr_req <= en_SEQ;
            state    <= S_REQ;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: begin
          done     <= 1'b0;
          overflow <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_loader.sv
// Self-checking bench for seq_loader: rule-level model feeds a scoreboard that
// an independent monitor drains whenever the DUT writes or signals done.
module tb_seq_loader;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n_SEQ;
  logic              en_SEQ;
  logic              start;
  logic              mode;
  logic              clear;
  logic              lfsr_valid;
  logic [DATA_W-1:0] lfsr_data;
  logic              lfsr_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [AW:0]       count;
  logic              busy;
  logic              done;
  logic              overflow;

  seq_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n_SEQ  (rst_n_SEQ),
    .en_SEQ     (en_SEQ),
    .start      (start),
    .mode       (mode),
    .clear      (clear),
    .lfsr_valid (lfsr_valid),
    .lfsr_data  (lfsr_data),
    .lfsr_req   (lfsr_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int cnt;  int ovf;  int cyc; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int tests = 0;
  int fails = 0;
  int mcount = 0;
  bit en_h[int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a done.
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n_SEQ) begin
      we_prev <= 1'b0;
    end else begin
      we_prev <= mem_we;
      if (mem_we) begin
        if (we_prev) fail_now("we_pulse_len");
        else if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), w.addr);
          check("wr_data", 32'(mem_wdata), w.data);
          check("wr_cycle", cyc, w.cyc);
        end
      end
      if (overflow && !done) fail_now("overflow_without_done");
      if (done) begin
        if (dn_q.size() == 0) fail_now("unexpected_done");
        else begin
          dn_t d;
          d = dn_q.pop_front();
          check("done_count", 32'(count), d.cnt);
          check("done_overflow", 32'(overflow), d.ovf);
          check("done_cycle", cyc, d.cyc);
          check("done_busy", 32'(busy), 1);
        end
      end
    end
  end

  task automatic quiet();
    start = 1'b0; clear = 1'b0; mode = 1'b0; en_SEQ = 1'b1;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n_SEQ = 1'b0;
    quiet();
    @(negedge clk);
    wr_q.delete();
    dn_q.delete();
    mcount = 0;
    rst_n_SEQ = 1'b1;
  endtask

  // One operation. The model: a word is accepted at the first edge, at least
  // two edges into the request phase, where valid is high and enable has been
  // high on that edge and the two before it. FILL requests DEPTH words,
  // APPEND one, APPEND on a full memory goes straight to done with overflow.
  // vmode: 0 valid always high, 1 random. enp: 0 on, 1 random, 2 five-edge stall.
  task automatic run_op(input bit m, input bit clr, input int vmode, input int enp,
                        input bit junk, input bit step);
    int t0, r, e, done_e, left, widx;
    bit in_req, v, en_v, finished;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    start = 1'b1; mode = m; clear = clr; en_SEQ = 1'b1;
    lfsr_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    lfsr_data  = DATA_W'($urandom);
    t0 = cyc + 1;
    en_h[t0] = 1'b1;
    if (clr) mcount = 0;
    if (!m)  mcount = 0;
    widx = 0;
    finished = 1'b0;
    if (m && mcount == DEPTH) begin
      dn_q.push_back('{cnt: mcount, ovf: 1, cyc: t0});
      done_e = t0; in_req = 1'b0; left = 0; r = t0;
    end else begin
      in_req = 1'b1; r = t0; done_e = -1;
      left = m ? 1 : DEPTH;
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      e = cyc + 1;
      if (enp == 2 && cyc >= t0 + 2 && cyc <= t0 + 6) check("stall_req_low", 32'(lfsr_req), 0);
      if (done_e >= 0 && e > done_e + 1) begin
        quiet();
        finished = 1'b1;
        break;
      end
      case (enp)
        1:       en_v = ($urandom_range(0, 7) != 0);
        2:       en_v = !(e >= t0 + 2 && e <= t0 + 6);
        default: en_v = 1'b1;
      endcase
      v = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      d = step ? DATA_W'(8'hA1 + widx) : DATA_W'($urandom);
      en_SEQ = en_v; lfsr_valid = v; lfsr_data = d;
      start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      clear = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      mode  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      en_h[e] = en_v;
      if (in_req && e >= r + 2 && v && en_h[e] && en_h[e-1] && en_h[e-2]) begin
        wr_q.push_back('{addr: mcount, data: int'(d), cyc: e});
        mcount++; left--; widx++;
        if (left == 0) begin
          in_req = 1'b0;
          done_e = e + 1;
          dn_q.push_back('{cnt: mcount, ovf: 0, cyc: e + 1});
        end else begin
          r = e + 1;
        end
      end
    end
    if (!finished) begin
      fail_now("op_timeout");
      hard_reset();
    end
  endtask

  // start and clear presented while disabled in IDLE must do nothing.
  task automatic idle_disabled();
    @(negedge clk);
    start = 1'b1; clear = 1'b1; mode = 1'b0; en_SEQ = 1'b0;
    @(negedge clk);
    quiet();
  endtask

  initial begin
    int t0;
    rst_n_SEQ  = 1'b0;
    start      = 1'b1;
    mode       = 1'b1;
    clear      = 1'b1;
    en_SEQ     = 1'b1;
    lfsr_valid = 1'b1;
    lfsr_data  = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_lfsr_req", 32'(lfsr_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
    quiet();
    lfsr_valid = 1'b1;
    rst_n_SEQ = 1'b1;

    // FILL with valid held high from before start, data stepping A1..A4.
    run_op(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("fill_count", 32'(count), DEPTH);

    // APPEND rounds after a clear, then one rejected append.
    run_op(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) run_op(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    check("append_full_count", 32'(count), DEPTH);
    run_op(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    check("overflow_count_held", 32'(count), DEPTH);

    idle_disabled();
    check("disabled_clear_ignored", 32'(count), DEPTH);

    // Busy filtering, then an enable stall inside REQ.
    run_op(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    run_op(1'b1, 1'b1, 0, 2, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 0, 2, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++)
      run_op(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1, 1, 1'b1, 1'b0);

    // Async reset while the write strobe is high.
    @(negedge clk);
    quiet();
    start = 1'b1; lfsr_valid = 1'b1; lfsr_data = 8'h5C;
    t0 = cyc + 1;
    wr_q.push_back('{addr: 0, data: 8'h5C, cyc: t0 + 2});
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && cyc < t0 + 2; k++) @(negedge clk);
    #2;
    check("pre_reset_we", 32'(mem_we), 1);
    rst_n_SEQ = 1'b0;
    #1;
    check("async_we_drop", 32'(mem_we), 0);
    check("async_count", 32'(count), 0);
    check("async_busy", 32'(busy), 0);
    wr_q.delete();
    dn_q.delete();
    mcount = 0;
    @(negedge clk);
    rst_n_SEQ = 1'b1;

    run_op(1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
    check("post_reset_count", 32'(count), 1);

    repeat (3) @(negedge clk);
    check("wr_queue_drained", wr_q.size(), 0);
    check("done_queue_drained", dn_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
